// File: rtl/apb_master_bridge.sv
// CPU single-request bus to APB4 initiator (IDLE -> SETUP -> ACCESS).
// Optional ACCESS-phase timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_write,
   input  logic [3:0]        req_wstrb,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic              psel,
   output logic              penable,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   output logic [3:0]        pstrb,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pslverr
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

   state_e              state_q, state_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic                pwrite_q, pwrite_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [3:0]          pstrb_q, pstrb_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_error_q, rsp_error_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0]         to_cnt_q, to_cnt_d;
`else
   logic                unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = '0;
`ifdef APB_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               // Misaligned requests are answered locally and never reach APB
               if (req_addr[1:0] != 2'b00) begin
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
               end else begin
                  paddr_d   = req_addr;
                  pwrite_d  = req_write;
                  pwdata_d  = req_write ? req_wdata : '0;
                  pstrb_d   = req_write ? req_wstrb : '0;
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  state_d   = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
         end
         S_ACCESS: begin
            if (pready) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_error_d = pslverr;
               rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
               state_d     = S_IDLE;
            end
`ifdef APB_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign paddr     = paddr_q;
   assign pwrite    = pwrite_q;
   assign pwdata    = pwdata_q;
   assign pstrb     = pstrb_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_error = rsp_error_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level model drives an APB slave and predicts
// per-cycle bus activity, response latency, error and read data.
module tb_apb_master_bridge;

   localparam int unsigned TO = 4;
`ifdef APB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic        psel;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [31:0] last_paddr, last_pwdata;
   logic        last_pwrite;
   logic [3:0]  last_pstrb;

   apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready), .prdata(prdata), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_held(input string tag);
      chk32({tag, "_paddr"}, paddr, last_paddr);
      chk1({tag, "_pwrite"}, pwrite, last_pwrite);
      chk32({tag, "_pwdata"}, pwdata, last_pwdata);
      chk32({tag, "_pstrb"}, {28'd0, pstrb}, {28'd0, last_pstrb});
   endtask

   task automatic scramble_req();
      req_addr  = $urandom;
      req_write = 1'($urandom);
      req_wstrb = 4'($urandom);
      req_wdata = $urandom;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         pready  = 1'($urandom);
         prdata  = $urandom;
         pslverr = 1'($urandom);
         @(negedge clk);
         chk1("idle_psel", psel, 1'b0);
         chk1("idle_rsp_valid", rsp_valid, 1'b0);
         chk1("idle_req_ready", req_ready, 1'b1);
         chk_held("idle_hold");
      end
   endtask

   // Called at a negedge with the bridge idle; returns at the negedge of the response cycle.
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [3:0] strb,
                       input logic [31:0] wd, input int unsigned waits,
                       input logic serr, input logic [31:0] rd);
      bit          mis;
      bit          abort;
      int unsigned nacc;
      logic [31:0] exp_wd;
      logic [3:0]  exp_st;
      logic        exp_err;
      logic [31:0] exp_rd;
      mis     = (addr[1:0] != 2'b00);
      abort   = TO_EN && (waits >= TO);
      nacc    = abort ? TO : waits + 1;
      exp_wd  = wr ? wd : 32'd0;
      exp_st  = wr ? strb : 4'd0;
      exp_err = mis || abort || serr;
      exp_rd  = (!wr && !exp_err) ? rd : 32'd0;

      chk1("accept_req_ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_addr  = addr;
      req_write = wr;
      req_wstrb = strb;
      req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      scramble_req();

      if (mis) begin
         chk1("mis_psel", psel, 1'b0);
         chk1("mis_rsp_valid", rsp_valid, 1'b1);
         chk1("mis_rsp_error", rsp_error, 1'b1);
         chk32("mis_rsp_rdata", rsp_rdata, 32'd0);
         chk1("mis_req_ready", req_ready, 1'b1);
         chk_held("mis_hold");
      end else begin
         chk1("setup_psel", psel, 1'b1);
         chk1("setup_penable", penable, 1'b0);
         chk1("setup_req_ready", req_ready, 1'b0);
         chk1("setup_rsp_valid", rsp_valid, 1'b0);
         chk32("setup_paddr", paddr, addr);
         chk1("setup_pwrite", pwrite, wr);
         chk32("setup_pwdata", pwdata, exp_wd);
         chk32("setup_pstrb", {28'd0, pstrb}, {28'd0, exp_st});
         // slave signals during SETUP are junk the bridge must ignore
         pready  = 1'b1;
         prdata  = $urandom;
         pslverr = 1'($urandom);
         @(negedge clk);
         for (int unsigned a = 0; a < nacc; a++) begin
            chk1("acc_psel", psel, 1'b1);
            chk1("acc_penable", penable, 1'b1);
            chk1("acc_req_ready", req_ready, 1'b0);
            chk1("acc_rsp_valid", rsp_valid, 1'b0);
            chk32("acc_paddr", paddr, addr);
            chk1("acc_pwrite", pwrite, wr);
            chk32("acc_pwdata", pwdata, exp_wd);
            chk32("acc_pstrb", {28'd0, pstrb}, {28'd0, exp_st});
            if (!abort && a == waits) begin
               pready  = 1'b1;
               prdata  = rd;
               pslverr = serr;
            end else begin
               pready  = 1'b0;
               prdata  = $urandom;
               pslverr = 1'($urandom);
            end
            @(negedge clk);
         end
         pready  = 1'($urandom);
         prdata  = $urandom;
         pslverr = 1'($urandom);
         chk1("rsp_psel", psel, 1'b0);
         chk1("rsp_penable", penable, 1'b0);
         chk1("rsp_valid", rsp_valid, 1'b1);
         chk1("rsp_error", rsp_error, exp_err);
         chk32("rsp_rdata", rsp_rdata, exp_rd);
         chk1("rsp_req_ready", req_ready, 1'b1);
         last_paddr  = addr;
         last_pwrite = wr;
         last_pwdata = exp_wd;
         last_pstrb  = exp_st;
         chk_held("rsp_hold");
      end
   endtask

   task automatic clear_last();
      last_paddr  = '0;
      last_pwrite = 1'b0;
      last_pwdata = '0;
      last_pstrb  = '0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      req_write = 1'b0;
      req_wstrb = '0;
      req_wdata = '0;
      pready    = 1'b0;
      prdata    = '0;
      pslverr   = 1'b0;
      clear_last();
      repeat (3) @(negedge clk);

      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_psel", psel, 1'b0);
      chk1("rst_penable", penable, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_rsp_error", rsp_error, 1'b0);
      chk32("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk_held("rst");
      rst = 1'b0;
      idle(2);

      // directed cases
      xfer(32'h0000_1004, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
      xfer(32'h0000_2000, 1'b1, 4'h1, 32'h0000_00A5, 3, 1'b0, 32'hFFFF_FFFF);
      idle(2);
      xfer(32'h0000_3008, 1'b0, 4'hF, 32'h5555_5555, 1, 1'b1, 32'h1234_5678);
      xfer(32'h0000_2002, 1'b1, 4'hF, 32'hCAFE_F00D, 0, 1'b0, 32'h0);
      idle(1);
      xfer(32'h0000_400C, 1'b1, 4'h0, 32'hA5A5_A5A5, 2, 1'b0, 32'h0);
      xfer(32'h0000_4010, 1'b1, 4'hC, 32'h0BAD_CAFE, 0, 1'b1, 32'h7777_7777);

      // reset during the second wait cycle of a read
      req_valid = 1'b1;
      req_addr  = 32'h0000_5000;
      req_write = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      scramble_req();
      pready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk1("mid_pre_psel", psel, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk1("mid_rst_psel", psel, 1'b0);
      chk1("mid_rst_penable", penable, 1'b0);
      chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk1("mid_rst_req_ready", req_ready, 1'b1);
      rst = 1'b0;
      clear_last();
      idle(3);
      xfer(32'h0000_1004, 1'b0, 4'h0, 32'h0, 0, 1'b0, 32'h1357_9BDF);

      // stuck slave: abort with timeout, otherwise wait indefinitely
`ifdef APB_TIMEOUT_EN
      xfer(32'h0000_6000, 1'b0, 4'h0, 32'h0, 50, 1'b0, 32'h2222_2222);
      xfer(32'h0000_6004, 1'b1, 4'h3, 32'h1111_0000, TO - 1, 1'b0, 32'h0);
`else
      req_valid = 1'b1;
      req_addr  = 32'h0000_6000;
      req_write = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      scramble_req();
      pready = 1'b0;
      for (int i = 0; i < 110; i++) begin
         @(negedge clk);
         chk1("hang_psel", psel, 1'b1);
         chk1("hang_rsp_valid", rsp_valid, 1'b0);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_last();
      idle(1);
`endif

      // randomized transfers
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         else a[1:0] = 2'b00;
         xfer(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 6),
              1'($urandom_range(0, 3) == 0), $urandom);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
